// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (transmitter, receiver, arbiter).
//   uart_arb_state_t : arbiter FSM state encoding (IDLE, SEND, HOLD)
//   UART_FRAME_BITS  : default bits per frame (start + 8 data + stop)
//   UART_GAP_BITS    : default idle bit times after each frame
//   cycles_per_bit() : clock cycles per bit time, truncating division
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_HOLD = 2'd2
    } uart_arb_state_t;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_GAP_BITS   = 1;

    function automatic int cycles_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational winner selection for uart_tx_arbiter.
//   i_req  [NUM_REQ] : request vector
//   i_ptr  [IW]      : index of the last granted requester (round-robin only)
//   o_gnt  [NUM_REQ] : one-hot winner (all zero when no request)
//   o_idx  [IW]      : index of the winner
// Configuration macro: UART_ARB_FIXED_PRI_EN -- when defined the block is a
// plain priority encoder (lowest index wins) and has no pointer input.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
`ifndef UART_ARB_FIXED_PRI_EN
    input  logic [IW-1:0]      i_ptr,
`endif
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx
);

`ifdef UART_ARB_FIXED_PRI_EN
    // Scan from the top down so the lowest set index is the last to write.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[IW'(k)]) begin
                o_gnt        = '0;
                o_gnt[IW'(k)] = 1'b1;
                o_idx        = IW'(k);
            end
        end
    end
`else
    logic          w_found;
    int            w_cand;
    logic [IW-1:0] w_sel;

    // Search starts one past the last winner and wraps modulo NUM_REQ, so the
    // last winner is considered last.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        w_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_sel = IW'(w_cand);
            if (!w_found && i_req[w_sel]) begin
                w_found      = 1'b1;
                o_gnt[w_sel] = 1'b1;
                o_idx        = w_sel;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte producers. One byte is
// accepted per frame; after each send pulse further sends are blocked for a
// full frame plus a guard gap, since the transmitter has no busy output.
//   clk              : system clock
//   rstn             : asynchronous active-low reset (shared with transmitter)
//   req      [N]     : per-requester request, held until granted
//   req_data [N][8]  : per-requester byte, stable while its req is high
//   grant    [N]     : one-hot single-cycle pulse, byte captured
//   tx_send          : single-cycle send pulse to the transmitter
//   tx_data  [8]     : byte to the transmitter, held until the next send
//   busy             : high whenever the FSM is not IDLE
//   owner    [log2N] : index of the most recent grant
// Configuration macro: UART_ARB_FIXED_PRI_EN -- fixed priority (lowest index
// wins, no round-robin pointer). Default is round-robin.
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FRAME_BITS = UART_FRAME_BITS,
    parameter int GAP_BITS   = UART_GAP_BITS
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0][7:0]    req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       tx_send,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD);
    localparam int HOLD_CYCLES    = (FRAME_BITS + GAP_BITS) * CYCLES_PER_BIT;
    localparam int IW             = $clog2(NUM_REQ);
    localparam int CW             = $clog2(HOLD_CYCLES + 1);

    if (CYCLES_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_arbiter: CLK_FREQ/BAUD must be at least 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end

    uart_arb_state_t    r_state;
    logic [CW-1:0]      r_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_tx_send;
    logic [7:0]         r_tx_data;
    logic               r_busy;
    logic [IW-1:0]      r_owner;
`ifndef UART_ARB_FIXED_PRI_EN
    logic [IW-1:0]      r_ptr;
`endif

    logic [NUM_REQ-1:0] w_win_gnt;
    logic [IW-1:0]      w_win_idx;
    logic               w_any;

    assign w_any = |req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_arbiter (
        .i_req   (req),
`ifndef UART_ARB_FIXED_PRI_EN
        .i_ptr   (r_ptr),
`endif
        .o_gnt   (w_win_gnt),
        .o_idx   (w_win_idx)
    );

    // grant/tx_send are registered on the edge that enters SEND, so they are
    // high exactly for the SEND cycle and low everywhere else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ARB_IDLE;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_tx_send <= 1'b0;
            r_tx_data <= 8'h00;
            r_busy    <= 1'b0;
            r_owner   <= '0;
`ifndef UART_ARB_FIXED_PRI_EN
            r_ptr     <= IW'(NUM_REQ - 1);
`endif
        end else begin
            r_grant   <= '0;
            r_tx_send <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state   <= ARB_SEND;
                        r_grant   <= w_win_gnt;
                        r_tx_send <= 1'b1;
                        r_tx_data <= req_data[w_win_idx];
                        r_owner   <= w_win_idx;
                        r_busy    <= 1'b1;
`ifndef UART_ARB_FIXED_PRI_EN
                        r_ptr     <= w_win_idx;
`endif
                    end
                end
                ARB_SEND: begin
                    // Counting HOLD_CYCLES-1 down to 0 gives HOLD_CYCLES cycles.
                    r_cnt   <= CW'(HOLD_CYCLES - 1);
                    r_state <= ARB_HOLD;
                end
                ARB_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ARB_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = r_grant;
    assign tx_send = r_tx_send;
    assign tx_data = r_tx_data;
    assign busy    = r_busy;
    assign owner   = r_owner;

endmodule
